if_id_stage: RTL and testbench



---
 rtl/if_id_stage_pkg.sv | 22 ++
 rtl/if_id_stage_fetch_check.sv | 31 +++
 rtl/if_id_stage.sv | 81 ++++++++
 tb/tb_if_id_stage.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared fetch-side constants: legal PC window, NOP word, exception codes
// and the IF/ID latch record.
package if_id_stage_pkg;

  localparam logic [31:0] PC_BASE_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_LAST_DEF = 32'h0000_6FFC;
  localparam logic [31:0] NOP_WORD    = '0;

  typedef enum logic [4:0] {
    EXC_NONE = 5'd0,
    EXC_ADEL = 5'd4
  } exc_code_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        bd;
    exc_code_e   exc;
  } if_id_t;

endpackage

// File: rtl/if_id_stage_fetch_check.sv
// Combinational fetch checks: instruction-memory word address, AdEL detection
// and selection of the fetched word (NOP on an illegal PC).
module fetch_check
  import if_id_stage_pkg::*;
#(
  parameter int unsigned IM_AW   = 12,
  parameter logic [31:0] PC_BASE = PC_BASE_DEF,
  parameter logic [31:0] PC_LAST = PC_LAST_DEF
) (
  input  logic [31:0]      pc_f,
  input  logic [31:0]      im_rdata,
  output logic [IM_AW-1:0] im_addr,
  output logic             adel_f,
  output logic [31:0]      word_f
);

  logic borrow;

  // Word-field subtraction equals (pc_f - PC_BASE)[IM_AW+1:2] once the borrow
  // out of the byte-offset bits is folded in.
  always_comb begin
    borrow  = (pc_f[1:0] < PC_BASE[1:0]);
    im_addr = pc_f[IM_AW+1:2] - PC_BASE[IM_AW+1:2] - IM_AW'(borrow);
  end

  always_comb begin
    adel_f = (pc_f[1:0] != 2'b00) || (pc_f < PC_BASE) || (pc_f > PC_LAST);
    word_f = adel_f ? NOP_WORD : im_rdata;
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline latch with stall, flush, delay-slot flag, AdEL code and a
// count of instructions accepted into ID.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int unsigned IM_AW   = 12,
  parameter logic [31:0] PC_BASE = PC_BASE_DEF,
  parameter logic [31:0] PC_LAST = PC_LAST_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_f,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  input  logic             stall,
  input  logic             flush,
  input  logic             bd_f,
  output logic [31:0]      instr_d,
  output logic [31:0]      pc_d,
  output logic             valid_d,
  output logic             bd_d,
  output logic [4:0]       exc_d,
  output logic [31:0]      fetch_cnt
);

  logic        adel_f;
  logic [31:0] word_f;

  if_id_t      latch_q, latch_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  fetch_check #(
    .IM_AW  (IM_AW),
    .PC_BASE(PC_BASE),
    .PC_LAST(PC_LAST)
  ) u_fetch_check (
    .pc_f    (pc_f),
    .im_rdata(im_rdata),
    .im_addr (im_addr),
    .adel_f  (adel_f),
    .word_f  (word_f)
  );

  // Flush outranks stall so a simultaneous request inserts a bubble.
  always_comb begin
    latch_d     = latch_q;
    fetch_cnt_d = fetch_cnt_q;
    if (flush) begin
      latch_d.instr = NOP_WORD;
      latch_d.pc    = pc_f;
      latch_d.valid = 1'b0;
      latch_d.bd    = 1'b0;
      latch_d.exc   = EXC_NONE;
    end else if (!stall) begin
      latch_d.instr = word_f;
      latch_d.pc    = pc_f;
      latch_d.valid = 1'b1;
      latch_d.bd    = bd_f;
      latch_d.exc   = adel_f ? EXC_ADEL : EXC_NONE;
      fetch_cnt_d   = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_q     <= '{instr: NOP_WORD, pc: PC_BASE, valid: 1'b0, bd: 1'b0, exc: EXC_NONE};
      fetch_cnt_q <= '0;
    end else begin
      latch_q     <= latch_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign instr_d   = latch_q.instr;
  assign pc_d      = latch_q.pc;
  assign valid_d   = latch_q.valid;
  assign bd_d      = latch_q.bd;
  assign exc_d     = latch_q.exc;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed vector bench for if_id_stage: a table of per-cycle stimulus with
// hand-computed expectations, plus a counter-wrap sequence.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f;
  logic [11:0] im_addr;
  logic [31:0] im_rdata;
  logic        stall;
  logic        flush;
  logic        bd_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic        bd_d;
  logic [4:0]  exc_d;
  logic [31:0] fetch_cnt;

  int unsigned checks = 0;
  int unsigned passes = 0;

  if_id_stage #(
    .IM_AW  (12),
    .PC_BASE(32'h0000_3000),
    .PC_LAST(32'h0000_6FFC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_f     (pc_f),
    .im_addr  (im_addr),
    .im_rdata (im_rdata),
    .stall    (stall),
    .flush    (flush),
    .bd_f     (bd_f),
    .instr_d  (instr_d),
    .pc_d     (pc_d),
    .valid_d  (valid_d),
    .bd_d     (bd_d),
    .exc_d    (exc_d),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        fls;
    logic        bdf;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [11:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_bd;
    logic [4:0]  e_exc;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passes++;
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc,
                          input logic e_valid, input logic e_bd, input logic [4:0] e_exc,
                          input logic [31:0] e_cnt);
    chk({tag, " instr_d"},   instr_d,          e_instr);
    chk({tag, " pc_d"},      pc_d,             e_pc);
    chk({tag, " valid_d"},   {31'd0, valid_d}, {31'd0, e_valid});
    chk({tag, " bd_d"},      {31'd0, bd_d},    {31'd0, e_bd});
    chk({tag, " exc_d"},     {27'd0, exc_d},   {27'd0, e_exc});
    chk({tag, " fetch_cnt"}, fetch_cnt,        e_cnt);
  endtask

  initial begin
    //          rst   stl   fls   bdf   pc            rdata         addr     instr         pc_d          v     bd    exc   cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_0000, 12'h000, 32'h0000_0000, 32'h0000_3000, 1'b0, 1'b0, 5'd0, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h3C01_1234, 12'h000, 32'h3C01_1234, 32'h0000_3000, 1'b1, 1'b0, 5'd0, 32'd1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3004, 32'h1111_1111, 12'h001, 32'h3C01_1234, 32'h0000_3000, 1'b1, 1'b0, 5'd0, 32'd1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3008, 32'h2222_2222, 12'h002, 32'h3C01_1234, 32'h0000_3000, 1'b1, 1'b0, 5'd0, 32'd1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_300C, 32'h3333_3333, 12'h003, 32'h3C01_1234, 32'h0000_3000, 1'b1, 1'b0, 5'd0, 32'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3010, 32'h4444_4444, 12'h004, 32'h4444_4444, 32'h0000_3010, 1'b1, 1'b0, 5'd0, 32'd2};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3002, 32'hDEAD_BEEF, 12'h000, 32'h0000_0000, 32'h0000_3002, 1'b1, 1'b0, 5'd4, 32'd3};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_7000, 32'hAAAA_5555, 12'h000, 32'h0000_0000, 32'h0000_7000, 1'b1, 1'b0, 5'd4, 32'd4};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2FFC, 32'h5555_AAAA, 12'hFFF, 32'h0000_0000, 32'h0000_2FFC, 1'b1, 1'b0, 5'd4, 32'd5};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_6FFC, 32'h1234_5678, 12'hFFF, 32'h1234_5678, 32'h0000_6FFC, 1'b1, 1'b0, 5'd0, 32'd6};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3014, 32'h1000_0003, 12'h005, 32'h1000_0003, 32'h0000_3014, 1'b1, 1'b1, 5'd0, 32'd7};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3018, 32'h8C01_0000, 12'h006, 32'h8C01_0000, 32'h0000_3018, 1'b1, 1'b0, 5'd0, 32'd8};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3010, 32'hFFFF_FFFF, 12'h004, 32'h0000_0000, 32'h0000_3010, 1'b0, 1'b0, 5'd0, 32'd8};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_7000, 32'h0BAD_0BAD, 12'h000, 32'h0000_0000, 32'h0000_7000, 1'b0, 1'b0, 5'd0, 32'd8};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3020, 32'h2402_0001, 12'h008, 32'h2402_0001, 32'h0000_3020, 1'b1, 1'b1, 5'd0, 32'd9};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_3024, 32'h7777_7777, 12'h009, 32'h0000_0000, 32'h0000_3000, 1'b0, 1'b0, 5'd0, 32'd0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3001, 32'h9999_9999, 12'h000, 32'h0000_0000, 32'h0000_3001, 1'b1, 1'b0, 5'd4, 32'd1};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_3028, 32'h6666_6666, 12'h00A, 32'h0000_0000, 32'h0000_3000, 1'b0, 1'b0, 5'd0, 32'd0};

    reset = 1'b1; stall = 1'b0; flush = 1'b0; bd_f = 1'b0;
    pc_f = 32'h0000_3000; im_rdata = '0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      reset    = vecs[i].rst;
      stall    = vecs[i].stl;
      flush    = vecs[i].fls;
      bd_f     = vecs[i].bdf;
      pc_f     = vecs[i].pc;
      im_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d im_addr", i), {20'd0, im_addr}, {20'd0, vecs[i].e_addr});
      @(posedge clk);
      #1;
      chk_outs($sformatf("v%0d", i), vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_valid,
               vecs[i].e_bd, vecs[i].e_exc, vecs[i].e_cnt);
    end

    // Counter wrap: preload the count while stalled, then do one load.
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; stall = 1'b1; bd_f = 1'b0;
    pc_f = 32'h0000_3030; im_rdata = 32'hCAFE_F00D;
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_q;
    @(posedge clk);
    #1;
    chk("wrap preload fetch_cnt", fetch_cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk);
    #1;
    chk_outs("wrap load", 32'hCAFE_F00D, 32'h0000_3030, 1'b1, 1'b0, 5'd0, 32'd0);

    // Stall held across a changing fetch, then one more load counts from zero.
    @(negedge clk);
    stall = 1'b1; pc_f = 32'h0000_3034; im_rdata = 32'h0101_0101;
    @(posedge clk);
    @(negedge clk);
    pc_f = 32'h0000_3038; im_rdata = 32'h0202_0202;
    @(posedge clk);
    #1;
    chk_outs("long stall", 32'hCAFE_F00D, 32'h0000_3030, 1'b1, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    stall = 1'b0; pc_f = 32'h0000_303C; im_rdata = 32'h0303_0303;
    @(posedge clk);
    #1;
    chk_outs("after stall", 32'h0303_0303, 32'h0000_303C, 1'b1, 1'b0, 5'd0, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
